// File: rtl/tanimoto_pkg.sv
// Shared definitions for the Tanimoto job controller: FSM encoding and
// bus/threshold-table geometry helpers.
package tanimoto_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CALC,
        ST_PROG,
        ST_STREAM,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam int DEF_BUS_WIDTH    = 128;
    localparam int DEF_VECTOR_WIDTH = 920;

    function automatic int bus_bytes(input int bus_width);
        return bus_width / 8;
    endfunction

    function automatic int bus_bytes_log2(input int bus_width);
        return $clog2(bus_width / 8);
    endfunction

    function automatic int cnt_width(input int vector_width);
        return $clog2(vector_width);
    endfunction

    // Largest value representable on the CNT_WIDTH+1 bit threshold data port
    function automatic int sat_max(input int cnt_w);
        return (1 << (cnt_w + 1)) - 1;
    endfunction

endpackage

// File: rtl/thr_table_writer.sv
// Programs threshold RAM addresses 0..VECTOR_WIDTH with saturated
// floor(n * factor) values, one write per cycle after a start pulse.
module thr_table_writer
    import tanimoto_pkg::*;
#(
    parameter int VECTOR_WIDTH = DEF_VECTOR_WIDTH,
    parameter int CNT_WIDTH    = cnt_width(VECTOR_WIDTH),
    parameter int FRAC_BITS    = 8,
    parameter int FACTOR_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [FACTOR_WIDTH-1:0] factor,
    output logic                    busy,
    output logic                    last,
    output logic [CNT_WIDTH-1:0]    bram_addr,
    output logic [CNT_WIDTH:0]      bram_wrdata,
    output logic                    bram_en,
    output logic                    bram_we
);

    localparam int ACC_WIDTH = FACTOR_WIDTH + CNT_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0] LAST_ADDR = CNT_WIDTH'(VECTOR_WIDTH);
    localparam logic [CNT_WIDTH:0]   SAT_VAL   = (CNT_WIDTH + 1)'(sat_max(CNT_WIDTH));

    logic                 active;
    logic [CNT_WIDTH-1:0] addr;
    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH-1:0] scaled;

    // Address and accumulator advance together; acc holds n*factor at address n
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active <= 1'b0;
            addr   <= '0;
            acc    <= '0;
        end else if (start && !active) begin
            active <= 1'b1;
            addr   <= '0;
            acc    <= '0;
        end else if (active) begin
            acc <= acc + ACC_WIDTH'(factor);
            if (addr == LAST_ADDR) begin
                active <= 1'b0;
            end else begin
                addr <= addr + 1'b1;
            end
        end
    end

    always_comb begin
        scaled      = acc >> FRAC_BITS;
        bram_wrdata = scaled[CNT_WIDTH:0];
        if (|scaled[ACC_WIDTH-1:CNT_WIDTH+1]) begin
            bram_wrdata = SAT_VAL;
        end
    end

    assign busy      = active;
    assign last      = active && (addr == LAST_ADDR);
    assign bram_addr = addr;
    assign bram_en   = active;
    assign bram_we   = active;

endmodule

// File: rtl/tanimoto_job_ctrl.sv
// Job sequencer: programs the threshold table, gates exactly one job's worth
// of beats into the datapath with tlast, then waits for the ID-pair stream end.
module tanimoto_job_ctrl
    import tanimoto_pkg::*;
#(
    parameter int BUS_WIDTH          = DEF_BUS_WIDTH,
    parameter int VECTOR_WIDTH       = DEF_VECTOR_WIDTH,
    parameter int VECTOR_WIDTH_BYTES = 115,
    parameter int VEC_ID_WIDTH       = 8,
    parameter int CNT_WIDTH          = cnt_width(VECTOR_WIDTH),
    parameter int FRAC_BITS          = 8,
    parameter int FACTOR_WIDTH       = 16,
    parameter int BEAT_CNT_WIDTH     = 24,
    parameter int DRAIN_TIMEOUT      = 4096
) (
    input  logic                      ap_clk,
    input  logic                      ap_rstn,
    input  logic                      start,
    input  logic [VEC_ID_WIDTH-1:0]   ref_vec_no,
    input  logic [VEC_ID_WIDTH-1:0]   cmp_vec_no,
    input  logic [FACTOR_WIDTH-1:0]   thr_factor,
    input  logic                      skip_thr,
    output logic                      busy,
    output logic                      done,
    output logic                      timeout,
    output logic [BEAT_CNT_WIDTH-1:0] beat_cnt,
    input  logic [BUS_WIDTH-1:0]      S_AXIS_IN_tdata,
    input  logic                      S_AXIS_IN_tvalid,
    output logic                      S_AXIS_IN_tready,
    output logic [BUS_WIDTH-1:0]      M_AXIS_DATA_tdata,
    output logic                      M_AXIS_DATA_tvalid,
    output logic                      M_AXIS_DATA_tlast,
    input  logic                      M_AXIS_DATA_tready,
    input  logic                      MON_ID_PAIR_tvalid,
    input  logic                      MON_ID_PAIR_tready,
    input  logic                      MON_ID_PAIR_tlast,
    output logic [CNT_WIDTH-1:0]      BRAM_addr,
    output logic [CNT_WIDTH:0]        BRAM_wrdata,
    output logic                      BRAM_en,
    output logic                      BRAM_we
);

    localparam int BUS_BYTES   = bus_bytes(BUS_WIDTH);
    localparam int BUS_LOG2    = bus_bytes_log2(BUS_WIDTH);
    localparam int BYTES_WIDTH = 2 * VEC_ID_WIDTH + 7;
    localparam int DRAIN_CW    = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [DRAIN_CW-1:0] DRAIN_LAST = DRAIN_CW'(DRAIN_TIMEOUT - 1);

    state_t state, state_next;

    logic [VEC_ID_WIDTH-1:0]   ref_q;
    logic [VEC_ID_WIDTH-1:0]   cmp_q;
    logic [FACTOR_WIDTH-1:0]   factor_q;
    logic [BEAT_CNT_WIDTH-1:0] total_beats;
    logic                      idp_flag;
    logic [DRAIN_CW-1:0]       drain_cnt;

    logic [BYTES_WIDTH-1:0]    job_bytes;
    logic [BYTES_WIDTH-1:0]    beats_full;
    logic [BEAT_CNT_WIDTH-1:0] calc_beats;

    logic in_stream;
    logic in_drain;
    logic last_beat;
    logic stream_hs;
    logic mon_last;
    logic drain_hit;
    logic wr_start;
    logic wr_busy;
    logic wr_last;

    always_comb begin
        job_bytes  = (BYTES_WIDTH'(ref_q) + BYTES_WIDTH'(cmp_q)) * BYTES_WIDTH'(VECTOR_WIDTH_BYTES);
        beats_full = (job_bytes + BYTES_WIDTH'(BUS_BYTES - 1)) >> BUS_LOG2;
        calc_beats = BEAT_CNT_WIDTH'(beats_full);
    end

    assign in_stream = (state == ST_STREAM);
    assign in_drain  = (state == ST_DRAIN);
    assign last_beat = (beat_cnt == total_beats - BEAT_CNT_WIDTH'(1));
    assign stream_hs = in_stream && S_AXIS_IN_tvalid && M_AXIS_DATA_tready;
    assign mon_last  = MON_ID_PAIR_tvalid && MON_ID_PAIR_tready && MON_ID_PAIR_tlast;
    assign drain_hit = in_drain && !idp_flag && !mon_last && (drain_cnt == DRAIN_LAST);
    assign wr_start  = (state == ST_CALC) && !skip_thr && !wr_busy;

    always_ff @(posedge ap_clk or negedge ap_rstn) begin
        if (!ap_rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // An ID-pair tlast seen during DRAIN finishes the job on the next cycle
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start) state_next = ST_CALC;
            end
            ST_CALC: begin
                if (!skip_thr)            state_next = ST_PROG;
                else if (calc_beats == '0) state_next = ST_DONE;
                else                      state_next = ST_STREAM;
            end
            ST_PROG: begin
                if (wr_last) state_next = (total_beats == '0) ? ST_DONE : ST_STREAM;
            end
            ST_STREAM: begin
                if (stream_hs && last_beat) state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (idp_flag || mon_last || drain_hit) state_next = ST_DONE;
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rstn) begin
        if (!ap_rstn) begin
            ref_q       <= '0;
            cmp_q       <= '0;
            factor_q    <= '0;
            total_beats <= '0;
            beat_cnt    <= '0;
            idp_flag    <= 1'b0;
            drain_cnt   <= '0;
            timeout     <= 1'b0;
        end else begin
            if ((state == ST_IDLE) && start) begin
                ref_q    <= ref_vec_no;
                cmp_q    <= cmp_vec_no;
                factor_q <= thr_factor;
                timeout  <= 1'b0;
                beat_cnt <= '0;
                idp_flag <= 1'b0;
            end
            if (state == ST_CALC) begin
                total_beats <= calc_beats;
            end
            if (stream_hs) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
            if (mon_last && (in_stream || in_drain)) begin
                idp_flag <= 1'b1;
            end
            if (in_drain) begin
                drain_cnt <= drain_cnt + 1'b1;
            end else begin
                drain_cnt <= '0;
            end
            if (drain_hit) begin
                timeout <= 1'b1;
            end
        end
    end

    thr_table_writer #(
        .VECTOR_WIDTH (VECTOR_WIDTH),
        .CNT_WIDTH    (CNT_WIDTH),
        .FRAC_BITS    (FRAC_BITS),
        .FACTOR_WIDTH (FACTOR_WIDTH)
    ) u_thr_writer (
        .clk         (ap_clk),
        .rst_n       (ap_rstn),
        .start       (wr_start),
        .factor      (factor_q),
        .busy        (wr_busy),
        .last        (wr_last),
        .bram_addr   (BRAM_addr),
        .bram_wrdata (BRAM_wrdata),
        .bram_en     (BRAM_en),
        .bram_we     (BRAM_we)
    );

    // Upstream is stalled, never dropped, whenever the gate is closed
    assign busy               = (state != ST_IDLE);
    assign done               = (state == ST_DONE);
    assign M_AXIS_DATA_tdata  = S_AXIS_IN_tdata;
    assign M_AXIS_DATA_tvalid = in_stream && S_AXIS_IN_tvalid;
    assign S_AXIS_IN_tready   = in_stream && M_AXIS_DATA_tready;
    assign M_AXIS_DATA_tlast  = in_stream && last_beat;

endmodule
